// File: rtl/sram_mem_ctrl_pkg.sv
// rtl/sram_mem_ctrl_pkg.sv - shared types and constants for the SRAM controller
package sram_mem_ctrl_pkg;

    localparam int ARCH = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDW,
        RMW_RD,
        RMW_WR,
        ERR
    } ctrl_state_t;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// rtl/sram_mem_ctrl_if.sv - requester, response and SRAM signal bundle
interface sram_mem_ctrl_if #(
    parameter int RAM_WIDTH = sram_mem_ctrl_pkg::ARCH,
    parameter int ADDR_W    = 12
);
    logic [1:0]                 req_valid_in;
    logic [1:0]                 req_ready_out;
    logic [1:0]                 req_we_in;
    logic [1:0][1:0]            req_size_in;
    logic [1:0][ADDR_W-1:0]     req_addr_in;
    logic [1:0][RAM_WIDTH-1:0]  req_wdata_in;

    logic                       rsp_valid_out;
    logic                       rsp_id_out;
    logic                       rsp_err_out;
    logic [RAM_WIDTH-1:0]       rsp_rdata_out;

    logic [ADDR_W-1:0]          ram_addr_a_out;
    logic [RAM_WIDTH-1:0]       ram_din_a_out;
    logic                       ram_we_a_out;
    logic [ADDR_W-1:0]          ram_addr_b_out;
    logic                       ram_en_b_out;
    logic [RAM_WIDTH-1:0]       ram_dout_b_in;

    // Requesters plus the SRAM itself sit on the master side.
    modport master (
        output req_valid_in, req_we_in, req_size_in, req_addr_in, req_wdata_in, ram_dout_b_in,
        input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_err_out, rsp_rdata_out,
        input  ram_addr_a_out, ram_din_a_out, ram_we_a_out, ram_addr_b_out, ram_en_b_out
    );

    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_addr_in, req_wdata_in, ram_dout_b_in,
        output req_ready_out, rsp_valid_out, rsp_id_out, rsp_err_out, rsp_rdata_out,
        output ram_addr_a_out, ram_din_a_out, ram_we_a_out, ram_addr_b_out, ram_en_b_out
    );
endinterface

// File: rtl/sram_mem_ctrl_rr_arbiter_2.sv
// rtl/sram_mem_ctrl_rr_arbiter_2.sv - two-way round-robin arbiter with priority pointer
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);
    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic r_prio;

    // Lone requester always wins; on a tie the pointer decides.
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    // After serving requester i, hand the tie-break to the other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_advance) begin
            r_prio <= o_grant[0];
        end
    end
endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - shares one SRAM between LSU and loader, byte/half stores via RMW
module sram_mem_ctrl import sram_mem_ctrl_pkg::*; #(
    parameter  int RAM_WIDTH = ARCH,
    parameter  int RAM_DEPTH = 4096,
    localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    sram_mem_ctrl_if.slave bus
);
    ctrl_state_t           r_state, w_next_state;

    logic [1:0]            w_arb_valid;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_gid;

    logic                  w_req_we;
    logic [1:0]            w_req_size;
    logic [ADDR_W-1:0]     w_req_addr;
    logic [ADDR_W-1:0]     w_req_addr_al;
    logic [RAM_WIDTH-1:0]  w_req_wdata;
    logic                  w_misaligned;

    logic                  r_id;
    logic [1:0]            r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [RAM_WIDTH-1:0]  r_wdata;

    logic                  r_ram_we_a, w_ram_we_a;
    logic                  r_ram_en_b, w_ram_en_b;
    logic [ADDR_W-1:0]     r_ram_addr_a, w_ram_addr_a;
    logic [ADDR_W-1:0]     r_ram_addr_b, w_ram_addr_b;
    logic [RAM_WIDTH-1:0]  r_ram_din_a, w_ram_din_a;
    logic                  r_rsp_valid, w_rsp_valid;
    logic                  r_rsp_id, w_rsp_id;
    logic                  r_rsp_err, w_rsp_err;

    // Little-endian lane insert; the RAM has no byte enables.
    function automatic logic [RAM_WIDTH-1:0] store_merge(
        input logic [RAM_WIDTH-1:0] old_word,
        input logic [RAM_WIDTH-1:0] wdata,
        input logic [1:0]           size,
        input logic [1:0]           offset
    );
        logic [RAM_WIDTH-1:0] merged;
        merged = old_word;
        if (size == SZ_BYTE) begin
            merged[{offset, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_HALF) begin
            merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            merged = wdata;
        end
        return merged;
    endfunction

    // Requests are only visible to the arbiter while nothing is in flight.
    assign w_arb_valid = (r_state == IDLE) ? bus.req_valid_in : 2'b00;

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_arb_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign bus.req_ready_out = w_grant;
    assign w_accept          = |w_grant;
    assign w_gid             = w_grant[1];

    assign w_req_we      = bus.req_we_in[w_gid];
    assign w_req_size    = bus.req_size_in[w_gid];
    assign w_req_addr    = bus.req_addr_in[w_gid];
    assign w_req_wdata   = bus.req_wdata_in[w_gid];
    assign w_req_addr_al = {w_req_addr[ADDR_W-1:2], 2'b00};

    // Loads ignore the low address bits; only stores can be misaligned.
    assign w_misaligned = w_req_we &
                          (((w_req_size == SZ_HALF) && w_req_addr[0]) ||
                           ((w_req_size != SZ_BYTE) && (w_req_size != SZ_HALF) &&
                            (w_req_addr[1:0] != 2'b00)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and next values of the registered RAM/response outputs.
    always_comb begin
        w_next_state = r_state;
        w_ram_we_a   = 1'b0;
        w_ram_en_b   = 1'b0;
        w_ram_addr_a = '0;
        w_ram_addr_b = '0;
        w_ram_din_a  = '0;
        w_rsp_valid  = 1'b0;
        w_rsp_id     = 1'b0;
        w_rsp_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_next_state = ERR;
                        w_rsp_valid  = 1'b1;
                        w_rsp_err    = 1'b1;
                        w_rsp_id     = w_gid;
                    end else if (!w_req_we) begin
                        w_next_state = RD;
                        w_ram_en_b   = 1'b1;
                        w_ram_addr_b = w_req_addr_al;
                    end else if ((w_req_size == SZ_BYTE) || (w_req_size == SZ_HALF)) begin
                        w_next_state = RMW_RD;
                        w_ram_en_b   = 1'b1;
                        w_ram_addr_b = w_req_addr_al;
                    end else begin
                        w_next_state = WR;
                        w_ram_we_a   = 1'b1;
                        w_ram_addr_a = w_req_addr_al;
                        w_ram_din_a  = w_req_wdata;
                        w_rsp_valid  = 1'b1;
                        w_rsp_id     = w_gid;
                    end
                end
            end
            RD: begin
                w_next_state = RDW;
                w_rsp_valid  = 1'b1;
                w_rsp_id     = r_id;
            end
            RMW_RD: begin
                w_next_state = RMW_WR;
                w_ram_we_a   = 1'b1;
                w_ram_addr_a = {r_addr[ADDR_W-1:2], 2'b00};
                w_rsp_valid  = 1'b1;
                w_rsp_id     = r_id;
            end
            WR, RDW, RMW_WR, ERR: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the granted request so later req_* changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_id    <= w_gid;
            r_size  <= w_req_size;
            r_addr  <= w_req_addr;
            r_wdata <= w_req_wdata;
        end
    end

    // Output registers; reset clears them at once so an aborted RMW cannot write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_we_a   <= 1'b0;
            r_ram_en_b   <= 1'b0;
            r_ram_addr_a <= '0;
            r_ram_addr_b <= '0;
            r_ram_din_a  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_ram_we_a   <= w_ram_we_a;
            r_ram_en_b   <= w_ram_en_b;
            r_ram_addr_a <= w_ram_addr_a;
            r_ram_addr_b <= w_ram_addr_b;
            r_ram_din_a  <= w_ram_din_a;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_id     <= w_rsp_id;
            r_rsp_err    <= w_rsp_err;
        end
    end

    // Read data arrives in the same cycle it is consumed, so the merged store word
    // and the load data are steered from the RAM output by the registered state.
    assign bus.ram_din_a_out  = (r_state == RMW_WR) ?
                                store_merge(bus.ram_dout_b_in, r_wdata, r_size, r_addr[1:0]) :
                                r_ram_din_a;
    assign bus.rsp_rdata_out  = (r_state == RDW) ? bus.ram_dout_b_in : '0;

    assign bus.ram_we_a_out   = r_ram_we_a;
    assign bus.ram_en_b_out   = r_ram_en_b;
    assign bus.ram_addr_a_out = r_ram_addr_a;
    assign bus.ram_addr_b_out = r_ram_addr_b;
    assign bus.rsp_valid_out  = r_rsp_valid;
    assign bus.rsp_id_out     = r_rsp_id;
    assign bus.rsp_err_out    = r_rsp_err;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - scoreboard bench for sram_mem_ctrl against a byte-array model
module tb_sram_mem_ctrl;

    logic clk;
    logic rst;

    sram_mem_ctrl_if bus ();

    sram_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        id;
        bit        we;
        bit [1:0]  sz;
        bit [11:0] addr;
        bit [31:0] wdata;
        int        acc;
    } op_t;

    op_t           q[$];
    byte unsigned  ref_mem [4096];
    logic [31:0]   sram [1024];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            we_cnt = 0;
    bit            prio = 0;

    always #5 clk = ~clk;

    // Behavioural SRAM: synchronous write on A, one-cycle read on B.
    always @(posedge clk) begin
        if (bus.ram_we_a_out) sram[bus.ram_addr_a_out[11:2]] <= bus.ram_din_a_out;
        if (bus.ram_en_b_out) bus.ram_dout_b_in <= sram[bus.ram_addr_b_out[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic bit misal(input bit [1:0] sz, input bit [11:0] a);
        return ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
    endfunction

    // Monitor: grant rule, response scoreboard, latency, RAM port exclusion.
    always @(negedge clk) begin : monitor
        op_t       o;
        logic [1:0] vld;
        logic [1:0] exp_g;
        bit [31:0] exp_rd;
        bit        exp_err;
        int        lat;
        bit [11:0] b;
        cyc++;
        if (rst) begin
            q.delete();
            prio = 0;
            chk("rst_outputs", 32'({bus.rsp_valid_out, bus.rsp_id_out, bus.rsp_err_out,
                                    bus.ram_we_a_out, bus.ram_en_b_out, bus.req_ready_out,
                                    |bus.rsp_rdata_out, |bus.ram_din_a_out,
                                    |bus.ram_addr_a_out, |bus.ram_addr_b_out}), 32'd0);
        end else begin
            chk("we_en_excl", 32'(bus.ram_we_a_out & bus.ram_en_b_out), 32'd0);
            if (bus.ram_we_a_out) we_cnt++;

            vld = bus.req_valid_in;
            if (q.size() != 0) exp_g = 2'b00;
            else if (vld == 2'b11) exp_g = prio ? 2'b10 : 2'b01;
            else exp_g = vld;
            if (vld != 2'b00) chk("grant", 32'(bus.req_ready_out), 32'(exp_g));

            chk("rsp_expected", 32'(bus.rsp_valid_out && (q.size() == 0)), 32'd0);
            if (bus.rsp_valid_out && (q.size() != 0)) begin
                o = q.pop_front();
                b = {o.addr[11:2], 2'b00};
                if (!o.we) begin
                    exp_err = 0;
                    exp_rd  = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
                    lat     = 2;
                end else if (misal(o.sz, o.addr)) begin
                    exp_err = 1;
                    exp_rd  = 0;
                    lat     = 1;
                end else begin
                    exp_err = 0;
                    exp_rd  = 0;
                    lat     = (o.sz == 2'd2) ? 1 : 2;
                    for (int k = 0; k < (1 << o.sz); k++) ref_mem[int'(o.addr) + k] = o.wdata[8*k +: 8];
                end
                chk("rsp_id", 32'(bus.rsp_id_out), 32'(o.id));
                chk("rsp_err", 32'(bus.rsp_err_out), 32'(exp_err));
                chk("rsp_rdata", bus.rsp_rdata_out, exp_rd);
                chk("rsp_latency", 32'(cyc - o.acc), 32'(lat));
            end else if (!bus.rsp_valid_out && (q.size() != 0)) begin
                if (cyc - q[0].acc > 3) begin
                    chk("rsp_timeout", 32'(cyc - q[0].acc), 32'd2);
                    void'(q.pop_front());
                end
            end

            if ((exp_g != 2'b00) && (bus.req_ready_out == exp_g)) begin
                o.id    = exp_g[1];
                o.we    = bus.req_we_in[exp_g[1]];
                o.sz    = bus.req_size_in[exp_g[1]];
                o.addr  = bus.req_addr_in[exp_g[1]];
                o.wdata = bus.req_wdata_in[exp_g[1]];
                o.acc   = cyc;
                q.push_back(o);
                prio = exp_g[0];
            end
        end
    end

    task automatic set_req(input int i, input bit we, input bit [1:0] sz,
                           input bit [11:0] a, input bit [31:0] d);
        bus.req_we_in[i]    = we;
        bus.req_size_in[i]  = sz;
        bus.req_addr_in[i]  = a;
        bus.req_wdata_in[i] = d;
        bus.req_valid_in[i] = 1'b1;
    endtask

    task automatic do_req(input int i, input bit we, input bit [1:0] sz,
                          input bit [11:0] a, input bit [31:0] d);
        int n;
        set_req(i, we, sz, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready_out[i] && (n < 30));
        chk("accept_timeout", 32'(n >= 30), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid_in[i] = 1'b0;
        bus.req_addr_in[i]  = 12'($urandom);
        bus.req_wdata_in[i] = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0) && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_mix(input int cycles, input bit rnd);
        bit [1:0] acc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc = bus.req_valid_in & bus.req_ready_out;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !bus.req_valid_in[i]) begin
                    bus.req_valid_in[i] = 1'b0;
                    if (!rnd)
                        set_req(i, 1'b0, 2'd2, 12'h200 + 12'($urandom_range(0, 15) * 4), 32'd0);
                    else if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                                12'h200 + 12'($urandom_range(0, 23)), $urandom);
                end
            end
        end
        bus.req_valid_in = 2'b00;
    endtask

    initial begin
        int w;
        clk = 0;
        rst = 1;
        bus.req_valid_in = '0;
        bus.req_we_in    = '0;
        bus.req_size_in  = '0;
        bus.req_addr_in  = '0;
        bus.req_wdata_in = '0;
        for (int i = 0; i < 1024; i++) sram[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // word store then load back
        do_req(0, 1, 2'd2, 12'h100, 32'hDEADBEEF);
        do_req(0, 0, 2'd2, 12'h100, 32'd0);
        wait_idle();

        // byte store via read-modify-write
        do_req(0, 1, 2'd0, 12'h101, 32'h000000AA);
        do_req(0, 0, 2'd0, 12'h100, 32'd0);
        wait_idle();

        // half store, then misaligned half store must not write
        do_req(0, 1, 2'd1, 12'h102, 32'h00001234);
        do_req(0, 0, 2'd2, 12'h100, 32'd0);
        wait_idle();
        w = we_cnt;
        do_req(0, 1, 2'd1, 12'h103, 32'h00005678);
        wait_idle();
        chk("err_no_write", 32'(we_cnt), 32'(w));
        do_req(1, 0, 2'd2, 12'h100, 32'd0);
        wait_idle();

        // both requesters loading back to back
        run_mix(24, 1'b0);
        wait_idle();

        // reset during the RMW write cycle of a byte store
        do_req(1, 1, 2'd2, 12'h104, 32'h11223344);
        wait_idle();
        w = we_cnt;
        do_req(1, 1, 2'd0, 12'h105, 32'h00000077);
        @(posedge clk);
        #1;
        rst = 1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_no_write", 32'(we_cnt), 32'(w));
        do_req(0, 0, 2'd2, 12'h104, 32'd0);
        wait_idle();

        // randomized traffic from both ports
        run_mix(1500, 1'b1);
        wait_idle();
        for (int a = 12'h200; a < 12'h218; a += 4) do_req(a[2], 0, 2'd2, 12'(a), 32'd0);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
